// File: rtl/draw_cmdctrl.sv
// rtl/draw_cmdctrl.sv - draw IP register window, show-ahead command FIFO and interrupt logic
module draw_cmdctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int          FIFO_AW   = 11,
    parameter int          THR_RESET = 2**(FIFO_AW-2)
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    input  logic        DRAW_BUSY,
    output logic        DRW_IRQ,
    output logic        REG_EXE,
    output logic        REG_RST,
    input  logic        CMD_RD_EN,
    output logic [31:0] CMD_RDATA,
    output logic        CMD_EMPTY,
    output logic        CMD_FULL
);
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 2**FIFO_AW;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count, thr, thr_wr;
    logic               exe, reg_rst, ovf, done, low, en_done, en_low;
    logic               busy_q, below_q, irq;
    logic [31:0]        rdata, rd_val;

    logic       wr_hit, rd_hit;
    logic [4:0] wr_off, rd_off;
    logic       wr_ctrl, wr_buf, wr_int, wr_thr;
    logic       full, empty, push_req, push, pop, ovf_set, done_set, below, low_set;

    assign wr_hit = WREN && (WRADDR[15:5] == BASE_ADDR[15:5]);
    assign rd_hit = RDEN && (RDADDR[15:5] == BASE_ADDR[15:5]);
    assign wr_off = WRADDR[4:0];
    assign rd_off = RDADDR[4:0];

    assign wr_ctrl = wr_hit && (wr_off == 5'h00) && BYTEEN[0];
    assign wr_buf  = wr_hit && (wr_off == 5'h08) && BYTEEN[2];
    assign wr_int  = wr_hit && (wr_off == 5'h10) && BYTEEN[0];
    assign wr_thr  = wr_hit && (wr_off == 5'h14);

    assign full     = count[FIFO_AW];
    assign empty    = (count == '0);
    assign pop      = CMD_RD_EN && !empty;
    assign push_req = wr_hit && (wr_off == 5'h0C) && (BYTEEN == 4'hF);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || CMD_RD_EN);
    assign ovf_set  = push_req && full && !CMD_RD_EN;
    assign done_set = busy_q && !DRAW_BUSY && exe;
    assign below    = (count < thr);
    assign low_set  = below && !below_q;

    always_comb begin
        thr_wr = thr;
        for (int i = 0; i < CW; i++) begin
            if (BYTEEN[i/8]) thr_wr[i] = WDATA[i];
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_off)
            5'h00:   rd_val = {30'b0, reg_rst, exe};
            5'h04:   rd_val = {31'b0, DRAW_BUSY};
            5'h08:   rd_val = {13'b0, ovf, full, empty, 16'(count)};
            5'h10:   rd_val = {28'b0, low, en_low, done, en_done};
            5'h14:   rd_val = 32'(thr);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push && !reg_rst) mem[wr_ptr] <= WDATA;
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            thr     <= CW'(THR_RESET);
            exe     <= 1'b0;
            reg_rst <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            low     <= 1'b0;
            en_done <= 1'b0;
            en_low  <= 1'b0;
            busy_q  <= 1'b0;
            below_q <= 1'b0;
            irq     <= 1'b0;
            rdata   <= '0;
        end else begin
            if (reg_rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                exe    <= 1'b0;
                ovf    <= 1'b0;
                done   <= 1'b0;
                low    <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);

                if (wr_ctrl) exe <= WDATA[0];
                // Hardware set beats a software clear landing in the same cycle.
                if (ovf_set)                     ovf <= 1'b1;
                else if (wr_buf && WDATA[18])    ovf <= 1'b0;
                if (done_set)                    done <= 1'b1;
                else if (wr_int && WDATA[1])     done <= 1'b0;
                if (low_set)                     low <= 1'b1;
                else if (wr_int && WDATA[3])     low <= 1'b0;
            end

            if (wr_int) begin
                en_done <= WDATA[0];
                en_low  <= WDATA[2];
            end
            if (wr_thr) thr <= thr_wr;

            reg_rst <= wr_ctrl && WDATA[1];
            busy_q  <= DRAW_BUSY;
            below_q <= below;
            irq     <= (done && en_done) || (low && en_low);
            rdata   <= rd_hit ? rd_val : 32'h0;
        end
    end

    assign RDATA     = rdata;
    assign DRW_IRQ   = irq;
    assign REG_EXE   = exe;
    assign REG_RST   = reg_rst;
    assign CMD_RDATA = empty ? 32'h0 : mem[rd_ptr];
    assign CMD_EMPTY = empty;
    assign CMD_FULL  = full;
endmodule

// File: tb/tb_draw_cmdctrl.sv
// tb/tb_draw_cmdctrl.sv - self-checking bench for draw_cmdctrl against a queue-based model
module tb_draw_cmdctrl;
    localparam logic [15:0] BASE  = 16'h2000;
    localparam int          AW    = 11;
    localparam int          DEPTH = 2**AW;
    localparam int          CW    = AW + 1;

    logic        CLK = 1'b0;
    logic        ARST = 1'b1;
    logic [15:0] WRADDR = '0;
    logic [3:0]  BYTEEN = '0;
    logic        WREN = 1'b0;
    logic [31:0] WDATA = '0;
    logic [15:0] RDADDR = '0;
    logic        RDEN = 1'b0;
    logic [31:0] RDATA;
    logic        DRAW_BUSY = 1'b0;
    logic        DRW_IRQ, REG_EXE, REG_RST;
    logic        CMD_RD_EN = 1'b0;
    logic [31:0] CMD_RDATA;
    logic        CMD_EMPTY, CMD_FULL;

    always #5 CLK = ~CLK;

    draw_cmdctrl #(.BASE_ADDR(BASE), .FIFO_AW(AW)) dut (
        .CLK(CLK), .ARST(ARST), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN),
        .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
        .DRAW_BUSY(DRAW_BUSY), .DRW_IRQ(DRW_IRQ), .REG_EXE(REG_EXE), .REG_RST(REG_RST),
        .CMD_RD_EN(CMD_RD_EN), .CMD_RDATA(CMD_RDATA), .CMD_EMPTY(CMD_EMPTY), .CMD_FULL(CMD_FULL)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, registers as plain variables.
    logic [31:0] mq[$];
    logic        m_exe, m_rst, m_ovf, m_done, m_low, m_en_done, m_en_low;
    logic        m_busy_prev, m_below_prev, m_irq;
    logic [CW-1:0] m_thr;
    logic [31:0] m_rdata;

    always @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            mq.delete();
            m_exe = 0; m_rst = 0; m_ovf = 0; m_done = 0; m_low = 0;
            m_en_done = 0; m_en_low = 0; m_busy_prev = 0; m_below_prev = 0;
            m_irq = 0; m_thr = CW'(DEPTH / 4); m_rdata = 0;
        end else begin : mdl
            int cnt;
            logic hw, hr, push_req, pop, dset, lset, below, new_rst, nirq;
            logic [4:0] ow, orr;
            logic [31:0] rv;
            cnt = mq.size();
            hw  = WREN && (WRADDR[15:5] == BASE[15:5]);
            hr  = RDEN && (RDADDR[15:5] == BASE[15:5]);
            ow  = WRADDR[4:0];
            orr = RDADDR[4:0];
            rv  = 0;
            if (hr) begin
                case (orr)
                    5'h00:   rv = {30'b0, m_rst, m_exe};
                    5'h04:   rv = {31'b0, DRAW_BUSY};
                    5'h08:   rv = {13'b0, m_ovf, cnt == DEPTH, cnt == 0, 16'(cnt)};
                    5'h10:   rv = {28'b0, m_low, m_en_low, m_done, m_en_done};
                    5'h14:   rv = 32'(m_thr);
                    default: rv = 0;
                endcase
            end
            push_req = hw && ow == 5'h0C && BYTEEN == 4'hF;
            pop      = CMD_RD_EN && cnt > 0;
            dset     = m_busy_prev && !DRAW_BUSY && m_exe;
            below    = cnt < m_thr;
            lset     = below && !m_below_prev;
            nirq     = (m_done && m_en_done) || (m_low && m_en_low);
            new_rst  = hw && ow == 5'h00 && BYTEEN[0] && WDATA[1];
            if (m_rst) begin
                mq.delete();
                m_ovf = 0; m_done = 0; m_low = 0; m_exe = 0;
            end else begin
                if (push_req && cnt == DEPTH && !CMD_RD_EN) m_ovf = 1;
                else if (hw && ow == 5'h08 && BYTEEN[2] && WDATA[18]) m_ovf = 0;
                if (pop) void'(mq.pop_front());
                if (push_req && (cnt < DEPTH || CMD_RD_EN)) mq.push_back(WDATA);
                if (dset) m_done = 1;
                else if (hw && ow == 5'h10 && BYTEEN[0] && WDATA[1]) m_done = 0;
                if (lset) m_low = 1;
                else if (hw && ow == 5'h10 && BYTEEN[0] && WDATA[3]) m_low = 0;
                if (hw && ow == 5'h00 && BYTEEN[0]) m_exe = WDATA[0];
            end
            if (hw && ow == 5'h10 && BYTEEN[0]) begin
                m_en_done = WDATA[0];
                m_en_low  = WDATA[2];
            end
            if (hw && ow == 5'h14)
                for (int i = 0; i < CW; i++) if (BYTEEN[i/8]) m_thr[i] = WDATA[i];
            m_busy_prev = DRAW_BUSY;
            m_below_prev = below;
            m_irq = nirq;
            m_rdata = rv;
            m_rst = new_rst;
        end
    end

    always @(negedge CLK) begin
        chk("rdata", RDATA, m_rdata);
        chk("irq", 32'(DRW_IRQ), 32'(m_irq));
        chk("reg_rst", 32'(REG_RST), 32'(m_rst));
        chk("reg_exe", 32'(REG_EXE), 32'(m_exe));
        chk("empty", 32'(CMD_EMPTY), 32'(mq.size() == 0));
        chk("full", 32'(CMD_FULL), 32'(mq.size() == DEPTH));
        if (mq.size() != 0) chk("head", CMD_RDATA, mq[0]);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be);
        WRADDR = BASE | 16'(off);
        WDATA  = d;
        BYTEEN = be;
        WREN   = 1;
        step();
        WREN   = 0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string name);
        RDADDR = BASE | 16'(off);
        RDEN   = 1;
        step();
        RDEN   = 0;
        chk(name, RDATA, exp);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 ARST = 0;

        rd(5'h14, 32'h0000_0200, "thr_reset");
        rd(5'h08, 32'h0001_0000, "bufstat_reset");
        chk("irq_reset", 32'(DRW_IRQ), 32'h0);

        for (int i = 0; i < DEPTH; i++) wr(5'h0C, i, 4'hF);
        rd(5'h08, 32'h0002_0800, "fill_full");
        wr(5'h0C, 32'hDEAD_BEEF, 4'hF);
        rd(5'h08, 32'h0006_0800, "overflow");

        chk("head_first", CMD_RDATA, 32'h0);
        WRADDR = BASE | 16'h0C; WDATA = 32'hAAAA_5555; BYTEEN = 4'hF; WREN = 1; CMD_RD_EN = 1;
        step();
        WREN = 0; CMD_RD_EN = 0;
        rd(5'h08, 32'h0006_0800, "full_push_pop");

        CMD_RD_EN = 1;
        for (int i = 1; i < DEPTH; i++) begin
            chk("pop_order", CMD_RDATA, i);
            step();
        end
        chk("pop_last", CMD_RDATA, 32'hAAAA_5555);
        step();
        CMD_RD_EN = 0;
        chk("drained", 32'(CMD_EMPTY), 32'h1);

        wr(5'h08, 32'h0004_0000, 4'h4);
        wr(5'h0C, 32'h1234_5678, 4'h3);
        rd(5'h08, 32'h0001_0000, "partial_push");
        rd(5'h10, 32'h0000_0008, "int_before");
        wr(5'h10, 32'h0000_000F, 4'h0);
        rd(5'h10, 32'h0000_0008, "int_be0");

        wr(5'h10, 32'h9, 4'h1);
        wr(5'h00, 32'h1, 4'h1);
        DRAW_BUSY = 1; step(); step();
        DRAW_BUSY = 0; step();
        chk("irq_lat1", 32'(DRW_IRQ), 32'h0);
        step();
        chk("done_irq", 32'(DRW_IRQ), 32'h1);
        wr(5'h10, 32'h3, 4'h1);
        step();
        chk("irq_cleared", 32'(DRW_IRQ), 32'h0);
        DRAW_BUSY = 1; step(); step();
        DRAW_BUSY = 0;
        wr(5'h10, 32'h3, 4'h1);
        rd(5'h10, 32'h0000_0003, "done_set_wins");

        wr(5'h10, 32'h5, 4'h1);
        for (int i = 0; i <= DEPTH; i++) wr(5'h0C, $urandom, 4'hF);
        CMD_RD_EN = 1;
        repeat (DEPTH - 100) step();
        CMD_RD_EN = 0;
        rd(5'h08, 32'h0004_0064, "pre_softrst");
        wr(5'h00, 32'h2, 4'h1);
        chk("softrst_pulse", 32'(REG_RST), 32'h1);
        step();
        chk("softrst_end", 32'(REG_RST), 32'h0);
        chk("softrst_empty", 32'(CMD_EMPTY), 32'h1);
        rd(5'h08, 32'h0001_0000, "softrst_buf");
        rd(5'h10, 32'h0000_0005, "softrst_int");
        rd(5'h00, 32'h0000_0000, "softrst_ctrl");
        rd(5'h14, 32'h0000_0200, "softrst_thr");

        for (int c = 0; c < 4000; c++) begin
            logic [4:0] off;
            if (c == 2000) begin
                WREN = 0; RDEN = 0; CMD_RD_EN = 0;
                #2 ARST = 1;
                #1;
                chk("arst_rdata", RDATA, 32'h0);
                chk("arst_empty", 32'(CMD_EMPTY), 32'h1);
                chk("arst_exe", 32'(REG_EXE), 32'h0);
                @(posedge CLK);
                #1 ARST = 0;
            end
            case ($urandom_range(0, 7))
                0: off = 5'h00;
                1: off = 5'h04;
                2: off = 5'h08;
                3, 4: off = 5'h0C;
                5: off = 5'h10;
                6: off = 5'h14;
                default: off = 5'($urandom);
            endcase
            WREN   = ($urandom_range(0, 2) == 0);
            WRADDR = ($urandom_range(0, 15) == 0) ? 16'($urandom) : (BASE | 16'(off));
            BYTEEN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            WDATA  = $urandom;
            if (off == 5'h14) WDATA = $urandom_range(0, 48);
            if (off == 5'h00) WDATA[1] = ($urandom_range(0, 15) == 0);
            RDEN      = ($urandom_range(0, 1) == 0);
            RDADDR    = ($urandom_range(0, 15) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 31)));
            CMD_RD_EN = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) DRAW_BUSY = ~DRAW_BUSY;
            step();
        end
        WREN = 0; RDEN = 0; CMD_RD_EN = 0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/draw_cmdctrl.md
Name: draw_cmdctrl

Overview:
Parametrised second-generation register controller and command buffer for the draw IP. It decodes a relocatable register window on the 16-bit register bus and buffers drawing commands in an internal, inferred, depth-parametrised FWFT FIFO. It generates a real interrupt from two sticky sources: draw-done, and FIFO low-watermark. It sits between the register bus and the draw engine, which pops commands through CMD_RD_EN.

Parameters:
BASE_ADDR, 16'h2000, register window base; must be 32-byte aligned.
FIFO_AW, 11, log2 of FIFO depth (depth = 2**FIFO_AW).
THR_RESET, 2**(FIFO_AW-2), reset value of the low-watermark threshold.

Ports:
CLK  in  1  clock
ARST  in  1  asynchronous active-high reset
WRADDR  in  16  write address
BYTEEN  in  4  write byte enables
WREN  in  1  write strobe
WDATA  in  32  write data
RDADDR  in  16  read address
RDEN  in  1  read strobe
RDATA  out  32  read data, registered
DRAW_BUSY  in  1  engine busy
DRW_IRQ  out  1  interrupt, registered
REG_EXE  out  1  execute enable (DRAWCTRL[0])
REG_RST  out  1  one-cycle soft-reset pulse
CMD_RD_EN  in  1  pop head word
CMD_RDATA  out  32  head word, valid while !CMD_EMPTY
CMD_EMPTY  out  1  FIFO empty
CMD_FULL  out  1  FIFO full

Behaviour:
- Clock and reset: one clock CLK. Reset ARST is asynchronous and active-high.
- ARST clears all state: every register and FIFO pointer is 0, except THR = THR_RESET and CMD_EMPTY = 1. All outputs are 0 except CMD_EMPTY.
- Decode: the window hits when ADDR[15:5] == BASE_ADDR[15:5]. The offset is ADDR[4:0]. Unmapped offsets ignore writes and read 0.
- Register map (CW = FIFO_AW+1):
  - +00 DRAWCTRL: [0] EXE RW; [1] RST, self-clears the cycle after it is set.
  - +04 DRAWSTAT: [0] DRAW_BUSY, RO.
  - +08 DRAWBUFSTAT: [CW-1:0] count; [16] EMPTY; [17] FULL; [18] OVF sticky, W1C.
  - +0C DRAWCMD: WO push; reads 0.
  - +10 DRAWINT: [0] EN_DONE RW; [1] DONE W1C; [2] EN_LOW RW; [3] LOW W1C.
  - +14 DRAWTHR: [CW-1:0] low threshold, RW.
- Byte enables:
  - RW and W1C fields honour BYTEEN per lane.
  - A DRAWCMD push requires BYTEEN == 4'hF; any partial write is dropped silently.
- Read: RDATA is valid 1 cycle after RDEN is sampled. RDATA is 0 in any cycle following RDEN = 0.
- FIFO:
  - Inferred memory of 2**FIFO_AW x 32. Show-ahead: CMD_RDATA presents the head word whenever !CMD_EMPTY.
  - A push is accepted when !FULL, or when FULL with CMD_RD_EN asserted in the same cycle (count unchanged).
  - A push to FULL without a pop is dropped and sets OVF.
  - CMD_RD_EN while EMPTY is ignored; pointers and count do not move.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo depth. count = 2**FIFO_AW means FULL.
- Soft reset:
  - A write with DRAWCTRL[1] = 1 raises REG_RST for exactly one cycle.
  - In that cycle the FIFO is flushed (count 0, EMPTY 1), OVF, DONE and LOW are cleared, and EXE is cleared.
  - Enables and THR are preserved.
  - A push in the REG_RST cycle is discarded.
- DONE event: falling edge of DRAW_BUSY (registered previous value 1, current 0), qualified by EXE = 1.
- LOW event: rising edge of (count < THR). THR = 0 never fires.
- Status priority: a hardware set of DONE, LOW or OVF wins over a W1C in the same cycle.
- Interrupt: DRW_IRQ <= (DONE & EN_DONE) | (LOW & EN_LOW), one-cycle registered delay. It deasserts the cycle after the last active status is cleared or disabled.
- Mid-operation ARST: FIFO contents are lost. Outputs return to reset values asynchronously.

Test Plan:
- Reset/readback: after ARST, read +14 -> 0x200 (FIFO_AW = 11); +08 -> 0x0001_0000; DRW_IRQ = 0.
- Fill/overflow: push 2048 words 0..2047 -> FULL = 1, count 0x800. Push one more -> dropped, OVF = 1. Pop all -> data 0..2047 in order, EMPTY = 1.
- Full with simultaneous push+pop: at FULL, push 0xAAAA_5555 with CMD_RD_EN = 1 -> count stays 0x800. Word 0xAAAA_5555 emerges last.
- Partial write: DRAWCMD write with BYTEEN = 4'h3 -> count unchanged. DRAWINT write BYTEEN = 0 -> no change.
- Done IRQ: EN_DONE = 1, EXE = 1, DRAW_BUSY 1 -> 0 -> DRW_IRQ = 1 two cycles after the edge. W1C 0x2 to +10 -> IRQ = 0 next cycle. W1C in the same cycle as a new falling edge -> DONE stays 1.
- Soft reset: 100 words queued, OVF = 1 -> write +00 = 0x2 -> REG_RST high 1 cycle, then count 0, OVF 0, EXE 0, EN bits kept.
